alarm_time_setter: RTL and testbench

- Upstream front-end for the alarm path of the complete clock.
- Turns two raw push-buttons into the BCD alarm time (Set_Hr, Set_Min) and an alarm-enable flag. These feed the BELL alarm module.
- Each button is synchronised and debounced. A three-state edit FSM selects the field being edited, and an inactivity timeout exits edit mode.
- A Blink output lets the display scanner flash the field being edited.

---
 rtl/alarm_time_setter.sv | 184 ++++++++++++++++++
 tb/tb_alarm_time_setter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_time_setter.sv
// Alarm-time front-end: two raw push-buttons become a BCD alarm time, an enable flag,
// an edit mode and a blink strobe for the field being edited.
// Latency: a clean key press reaches the output registers DEB_CYCLES+3 edges after the pin is first sampled low.
// Backpressure: none; every accepted press is acted on at once, and a held key yields a single event.
//
// Ports:
//   CLK_50     system clock
//   CR         asynchronous active-high reset
//   KeyMode_n  raw mode button, active-low, asynchronous to the clock
//   KeyInc_n   raw increment button, active-low, asynchronous to the clock
//   Set_Hr     alarm hour in BCD (00-23)
//   Set_Min    alarm minute in BCD (00-59)
//   AlarmEn    alarm armed
//   Mode       00 idle, 01 editing hours, 10 editing minutes
//   Blink      flash strobe for the edited field, 0 when idle
module alarm_time_setter #(
  parameter int          DEB_CYCLES     = 1000000,
  parameter int          BLINK_CYCLES   = 12500000,
  parameter int          TIMEOUT_CYCLES = 500000000,
  parameter logic [7:0]  RST_HR         = 8'h07,
  parameter logic [7:0]  RST_MIN        = 8'h00
) (
  input  logic       CLK_50,
  input  logic       CR,
  input  logic       KeyMode_n,
  input  logic       KeyInc_n,
  output logic [7:0] Set_Hr,
  output logic [7:0] Set_Min,
  output logic       AlarmEn,
  output logic [1:0] Mode,
  output logic       Blink
);

  localparam int DW = (DEB_CYCLES     > 1) ? $clog2(DEB_CYCLES)     : 1;
  localparam int BW = (BLINK_CYCLES   > 1) ? $clog2(BLINK_CYCLES)   : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [DW-1:0] DEB_LAST     = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  // Key index 0 is the mode button, index 1 the increment button.
  logic [1:0]    key_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    st_q, st_d;
  logic [1:0]    st_prev_q;
  logic [1:0]    press_q;
  logic [DW-1:0] dc_q [2];
  logic [DW-1:0] dc_d [2];

  state_t        state_q, state_d;
  logic [7:0]    hr_q, hr_d;
  logic [7:0]    min_q, min_d;
  logic          en_q, en_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [BW-1:0] bc_q, bc_d;

  logic          pm, pi;

  assign key_raw = {KeyInc_n, KeyMode_n};
  assign pm      = press_q[0];
  assign pi      = press_q[1];

  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    if (v == 8'h23)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_min(input logic [7:0] v);
    if (v == 8'h59)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Debounce: the stable value only follows the synchronised pin after
  // DEB_CYCLES consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    st_d = st_q;
    dc_d = dc_q;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] == st_q[k]) begin
        dc_d[k] = '0;
      end else if (dc_q[k] == DEB_LAST) begin
        st_d[k] = sync2_q[k];
        dc_d[k] = '0;
      end else begin
        dc_d[k] = dc_q[k] + DW'(1);
      end
    end
  end

  // Edit FSM, field updates, timeout and blink.
  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    en_d    = en_q;
    tc_d    = '0;
    blink_d = blink_q;
    bc_d    = bc_q;

    if (pm) begin
      // Mode press wins over a simultaneous increment press.
      unique case (state_q)
        IDLE:    state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        default: state_d = IDLE;
      endcase
    end else if (pi) begin
      unique case (state_q)
        IDLE:    en_d  = ~en_q;
        SET_HR:  hr_d  = inc_hr(hr_q);
        default: min_d = inc_min(min_q);
      endcase
    end else if (state_q != IDLE) begin
      // A press in the expiry cycle is handled above, which cancels the timeout.
      if (tc_q == TIMEOUT_LAST) state_d = IDLE;
      else                      tc_d    = tc_q + TW'(1);
    end

    if (state_d == IDLE) begin
      blink_d = 1'b0;
      bc_d    = '0;
    end else if (state_d != state_q) begin
      // Entering a field starts it visible with a fresh half-period.
      blink_d = 1'b1;
      bc_d    = '0;
    end else if (bc_q == BLINK_LAST) begin
      blink_d = ~blink_q;
      bc_d    = '0;
    end else begin
      bc_d    = bc_q + BW'(1);
    end
  end

  always_ff @(posedge CLK_50 or posedge CR) begin
    if (CR) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      st_q      <= 2'b11;
      st_prev_q <= 2'b11;
      press_q   <= 2'b00;
      dc_q[0]   <= '0;
      dc_q[1]   <= '0;
      state_q   <= IDLE;
      hr_q      <= RST_HR;
      min_q     <= RST_MIN;
      en_q      <= 1'b0;
      blink_q   <= 1'b0;
      tc_q      <= '0;
      bc_q      <= '0;
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      st_q      <= st_d;
      st_prev_q <= st_q;
      // Only the 1->0 (press) transition of the stable key makes an event.
      press_q   <= st_prev_q & ~st_q;
      dc_q      <= dc_d;
      state_q   <= state_d;
      hr_q      <= hr_d;
      min_q     <= min_d;
      en_q      <= en_d;
      blink_q   <= blink_d;
      tc_q      <= tc_d;
      bc_q      <= bc_d;
    end
  end

  assign Set_Hr  = hr_q;
  assign Set_Min = min_q;
  assign AlarmEn = en_q;
  assign Mode    = state_q;
  assign Blink   = blink_q;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Bench for alarm_time_setter with short debounce, blink and timeout periods.
// An event-level model predicts every output each cycle; literal checks pin key points.
module tb_alarm_time_setter;

  localparam int DEB = 4;
  localparam int BLK = 8;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       CR = 1'b0;
  logic       KeyMode_n = 1'b1;
  logic       KeyInc_n = 1'b1;
  logic [7:0] Set_Hr;
  logic [7:0] Set_Min;
  logic       AlarmEn;
  logic [1:0] Mode;
  logic       Blink;

  alarm_time_setter #(
    .DEB_CYCLES(DEB), .BLINK_CYCLES(BLK), .TIMEOUT_CYCLES(TMO),
    .RST_HR(8'h07), .RST_MIN(8'h00)
  ) dut (
    .CLK_50(clk), .CR(CR), .KeyMode_n(KeyMode_n), .KeyInc_n(KeyInc_n),
    .Set_Hr(Set_Hr), .Set_Min(Set_Min), .AlarmEn(AlarmEn), .Mode(Mode), .Blink(Blink)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;   // index of the most recent rising edge, read at the falling edge

  // Model: fields as plain integers, key events as (edge, kind) pairs.
  int mode_m = 0;
  int hr_m = 7;
  int min_m = 0;
  bit en_m = 1'b0;
  bit blink_m = 1'b0;
  int entry_m = 0;
  int last_m = 0;
  int ev_edge[$];
  int ev_kind[$];     // bit0 mode press, bit1 increment press

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got 0x%02h, expected 0x%02h", name, edge_cnt, got, exp);
    end
  endtask

  // Advance one cycle, update the model for the edge just passed, compare all outputs.
  task automatic next_cycle();
    int ev;
    @(negedge clk);
    edge_cnt++;
    ev = 0;
    if (CR) begin
      mode_m = 0; hr_m = 7; min_m = 0; en_m = 1'b0;
      entry_m = edge_cnt; last_m = edge_cnt;
      ev_edge.delete();
      ev_kind.delete();
    end else begin
      if (ev_edge.size() != 0 && ev_edge[0] == edge_cnt) begin
        ev = ev_kind[0];
        void'(ev_edge.pop_front());
        void'(ev_kind.pop_front());
      end
      if ((ev & 1) != 0) begin
        mode_m = (mode_m == 2) ? 0 : mode_m + 1;
        last_m = edge_cnt;
        if (mode_m != 0) entry_m = edge_cnt;
      end else if ((ev & 2) != 0) begin
        last_m = edge_cnt;
        case (mode_m)
          0:       en_m  = !en_m;
          1:       hr_m  = (hr_m + 1) % 24;
          default: min_m = (min_m + 1) % 60;
        endcase
      end else if (mode_m != 0 && edge_cnt - last_m == TMO) begin
        mode_m = 0;
      end
    end
    blink_m = (mode_m != 0) && (((edge_cnt - entry_m) / BLK) % 2 == 0);
    chk("Mode",    {6'b0, Mode},    8'(mode_m));
    chk("Set_Hr",  Set_Hr,          bcd(hr_m));
    chk("Set_Min", Set_Min,         bcd(min_m));
    chk("AlarmEn", {7'b0, AlarmEn}, {7'b0, en_m});
    chk("Blink",   {7'b0, Blink},   {7'b0, blink_m});
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) next_cycle();
  endtask

  // Clean press: low for 8 sampled edges, high for 8; the action lands DEB+3 edges after the first low sample.
  task automatic press(input bit m, input bit i, output int ev_at);
    int t;
    t = edge_cnt + 1;
    if (m) KeyMode_n = 1'b0;
    if (i) KeyInc_n = 1'b0;
    ev_at = t + DEB + 3;
    ev_edge.push_back(ev_at);
    ev_kind.push_back((m ? 1 : 0) | (i ? 2 : 0));
    wait_edge(t + 7);
    KeyMode_n = 1'b1;
    KeyInc_n = 1'b1;
    wait_edge(t + 15);
  endtask

  task automatic press_at(input bit m, input bit i, input int target, output int ev_at);
    wait_edge(target - DEB - 4);
    press(m, i, ev_at);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, t0;
    #1 CR = 1'b1;
    repeat (3) next_cycle();
    CR = 1'b0;
    repeat (3) next_cycle();

    // Bounce in IDLE: five short lows, then a solid low.
    for (int r = 0; r < 5; r++) begin
      KeyInc_n = 1'b0;
      repeat (3) next_cycle();
      KeyInc_n = 1'b1;
      next_cycle();
    end
    KeyInc_n = 1'b0;
    t0 = edge_cnt + 1;
    ev_edge.push_back(t0 + 7);
    ev_kind.push_back(2);
    wait_edge(t0 + 6);
    chk("bounce_before", {7'b0, AlarmEn}, 8'h00);
    next_cycle();
    chk("bounce_edge", {7'b0, AlarmEn}, 8'h01);
    wait_edge(t0 + 9);
    KeyInc_n = 1'b1;
    repeat (10) next_cycle();
    chk("bounce_once", {7'b0, AlarmEn}, 8'h01);

    // Hour wrap.
    press(1'b1, 1'b0, e);
    chk("enter_sethr", {6'b0, Mode}, 8'h01);
    chk("blink_first_toggle", {7'b0, Blink}, 8'h00);
    for (int k = 1; k <= 17; k++) begin
      press(1'b0, 1'b1, e);
      case (k)
        2:  chk("hr_09", Set_Hr, 8'h09);
        3:  chk("hr_10", Set_Hr, 8'h10);
        12: chk("hr_19", Set_Hr, 8'h19);
        13: chk("hr_20", Set_Hr, 8'h20);
        16: chk("hr_23", Set_Hr, 8'h23);
        17: chk("hr_00", Set_Hr, 8'h00);
        default: ;
      endcase
    end
    chk("hr_mode_kept", {6'b0, Mode}, 8'h01);

    // Minute wrap and exit.
    press(1'b1, 1'b0, e);
    chk("enter_setmin", {6'b0, Mode}, 8'h02);
    for (int k = 1; k <= 60; k++) begin
      press(1'b0, 1'b1, e);
      case (k)
        9:  chk("min_09", Set_Min, 8'h09);
        10: chk("min_10", Set_Min, 8'h10);
        59: chk("min_59", Set_Min, 8'h59);
        60: chk("min_00", Set_Min, 8'h00);
        default: ;
      endcase
    end
    press(1'b1, 1'b0, e);
    chk("exit_mode", {6'b0, Mode}, 8'h00);
    chk("exit_blink", {7'b0, Blink}, 8'h00);

    // Timeout with no keys.
    press(1'b1, 1'b0, e);
    wait_edge(e + TMO - 1);
    chk("tmo_49", {6'b0, Mode}, 8'h01);
    next_cycle();
    chk("tmo_50", {6'b0, Mode}, 8'h00);
    chk("tmo_hr_kept", Set_Hr, 8'h00);

    // Press landing in the expiry cycle cancels the timeout.
    press(1'b1, 1'b0, e);
    press_at(1'b0, 1'b1, e + TMO, e2);
    chk("tmo_cancel_mode", {6'b0, Mode}, 8'h01);
    chk("tmo_cancel_hr", Set_Hr, 8'h01);
    wait_edge(e2 + TMO - 1);
    chk("tmo2_49", {6'b0, Mode}, 8'h01);
    next_cycle();
    chk("tmo2_50", {6'b0, Mode}, 8'h00);

    // Both keys on the same edge in SET_HR.
    press(1'b1, 1'b0, e);
    press(1'b1, 1'b1, e);
    chk("simul_mode", {6'b0, Mode}, 8'h02);
    chk("simul_hr", Set_Hr, 8'h01);

    // Asynchronous reset in SET_MIN during a debounce.
    KeyInc_n = 1'b0;
    repeat (2) next_cycle();
    #2 CR = 1'b1;
    #1;
    chk("rst_hr", Set_Hr, 8'h07);
    chk("rst_min", Set_Min, 8'h00);
    chk("rst_en", {7'b0, AlarmEn}, 8'h00);
    chk("rst_mode", {6'b0, Mode}, 8'h00);
    chk("rst_blink", {7'b0, Blink}, 8'h00);
    KeyInc_n = 1'b1;
    repeat (3) next_cycle();
    CR = 1'b0;
    repeat (4) next_cycle();
    press(1'b0, 1'b1, e);
    chk("post_rst_en", {7'b0, AlarmEn}, 8'h01);
    chk("post_rst_hr", Set_Hr, 8'h07);
    repeat (4) next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
